// File: rtl/icache_bank_req_fifo_if.sv
// Handshake bundle between the arbitration tree, the bank request FIFO and the cache bank.
// The slave modport is the FIFO's view; the master modport is the surrounding logic's view.
interface icache_bank_req_fifo_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int UID_WIDTH     = 16,
  parameter int DEPTH         = 4
);
  logic                     flush_i;
  logic                     request_i;
  logic [ADDRESS_WIDTH-1:0] address_i;
  logic [UID_WIDTH-1:0]     UID_i;
  logic                     grant_o;
  logic                     request_o;
  logic [ADDRESS_WIDTH-1:0] address_o;
  logic [UID_WIDTH-1:0]     UID_o;
  logic                     grant_i;
  logic [$clog2(DEPTH):0]   occupancy_o;

  modport slave (
    input  flush_i, request_i, address_i, UID_i, grant_i,
    output grant_o, request_o, address_o, UID_o, occupancy_o
  );

  modport master (
    output flush_i, request_i, address_i, UID_i, grant_i,
    input  grant_o, request_o, address_o, UID_o, occupancy_o
  );
endinterface

// File: rtl/icache_bank_req_fifo.sv
// In-order request FIFO between the icache arbitration tree and one cache bank.
// Optional empty-FIFO combinational bypass: define ICACHE_INTC_FIFO_BYPASS_EN.
module icache_bank_req_fifo #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int UID_WIDTH     = 16,
  parameter int DEPTH         = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  icache_bank_req_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [UID_WIDTH-1:0]     uid;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               empty, full, grant, bypass, push, pop;
  entry_t             head;

`ifdef ICACHE_INTC_FIFO_BYPASS_EN
  // Keeps the bypass path quiet while reset is held and until the first edge after release.
  logic out_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_en_q <= 1'b0;
    else         out_en_q <= 1'b1;
  end

  assign bypass = out_en_q && empty && !bus.flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign head  = mem[rd_ptr_q];

  // Full blocks the grant even when the bank pops this cycle, so no same-cycle refill.
  assign grant = bus.request_i && !full && !bus.flush_i;
  assign push  = grant && !(bypass && bus.grant_i);
  assign pop   = !bus.flush_i && !empty && bus.grant_i;

  assign bus.grant_o     = grant;
  assign bus.request_o   = !bus.flush_i && (!empty || (bypass && bus.request_i));
  assign bus.occupancy_o = occ_q;

  always_comb begin
    bus.address_o = '0;
    bus.UID_o     = '0;
    if (!empty) begin
      bus.address_o = head.address;
      bus.UID_o     = head.uid;
    end else if (bypass) begin
      bus.address_o = bus.address_i;
      bus.UID_o     = bus.UID_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage has no reset; outputs are gated by occupancy so stale contents never escape.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= '{address: bus.address_i, uid: bus.UID_i};
  end

endmodule

// File: doc/icache_bank_req_fifo.md
ICACHE_BANK_REQ_FIFO -- requirements
Module: icache_bank_req_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDRESS_WIDTH, 32: request address width.
- UID_WIDTH, 16: one-hot requester ID width, one bit per core.
- DEPTH, 4: number of FIFO entries; must be a power of two and at least 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: the block's single clock.
- rst_ni, in, 1: asynchronous, active-low reset.
- flush_i, in, 1: synchronous clear of all queued entries.
- request_i, in, 1: upstream request from the arbitration tree.
- address_i, in, ADDRESS_WIDTH: upstream address.
- UID_i, in, UID_WIDTH: upstream requester ID.
- grant_o, out, 1: upstream grant.
- request_o, out, 1: request to the cache bank.
- address_o, out, ADDRESS_WIDTH: bank address.
- UID_o, out, UID_WIDTH: bank requester ID.
- grant_i, in, 1: bank grant.
- occupancy_o, out, $clog2(DEPTH)+1: number of valid entries.

Function
REQ-003 The block SHALL buffer granted upstream requests in order and present them to the cache bank, decoupling the arbitration tree from bank stalls.
REQ-004 grant_o SHALL equal request_i AND (occupancy_o < DEPTH) AND NOT flush_i; it is combinational.
REQ-005 A push SHALL occur when request_i and grant_o are both high; {address_i, UID_i} is written at the write pointer on the next rising edge.
REQ-006 request_o SHALL be high exactly when occupancy_o > 0 and flush_i is low; address_o and UID_o SHALL show the head entry.
REQ-007 A pop SHALL occur when request_o and grant_i are both high; the read pointer advances on the next rising edge.
REQ-008 address_o and UID_o SHALL hold stable while request_o is high and grant_i is low.
REQ-009 Minimum request_i-to-request_o latency SHALL be 1 cycle, except in the bypass case of REQ-016.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH with no bubble.
REQ-011 Occupancy SHALL follow the push/pop combination:
- push and pop in the same cycle: unchanged.
- push only: +1.
- pop only: -1.
REQ-012 When full, grant_o SHALL be 0 even if grant_i pops in the same cycle; no push is accepted until the next cycle.
REQ-013 Boundary states and their required behaviour:
- EMPTY (occ=0): request_o=0; grant_i is ignored.
- PARTIAL (0<occ<DEPTH): push and pop are both allowed.
- FULL (occ=DEPTH): grant_o=0.
REQ-014 flush_i high SHALL have the following effects:
- Occupancy and both pointers are cleared on the next edge.
- No push or pop occurs in that cycle.
- Flush takes priority over simultaneous push or pop.

Reset
REQ-015 While rst_ni is low, the block SHALL hold:
- Pointers and occupancy at 0.
- request_o=0, occupancy_o=0, address_o=0, UID_o=0.
- grant_o following REQ-004.
- Storage contents unspecified.
- Deassertion of rst_ni takes effect at the next clock edge.

Configuration
REQ-016 Macro ICACHE_INTC_FIFO_BYPASS_EN SHALL select the empty-FIFO bypass.
- Defined, with occupancy 0 and flush_i low:
  - request_o = request_i; address_o = address_i; UID_o = UID_i.
  - If grant_i=1, grant_o=1 and the request completes combinationally with no push.
  - If grant_i=0, the request is pushed normally when grant_o is high.
- Undefined: no combinational path from request_i to request_o; latency is always at least 1 cycle.
REQ-017 All other behaviour SHALL be identical with and without ICACHE_INTC_FIFO_BYPASS_EN.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then a single request addr=0x100, UID=0x0004, grant_i=1 -> grant_o=1 in that cycle; request_o=1, address_o=0x100, UID_o=0x0004 next cycle. With bypass: same cycle, occupancy stays 0.
- grant_i=0; 5 back-to-back requests with DEPTH=4 -> 4 grants; 5th grant_o=0; occupancy_o=4; then grant_i=1 for 4 cycles -> entries drain in order.
- Full FIFO, grant_i=1 and request_i=1 in the same cycle -> pop occurs, grant_o=0, occupancy 4->3; the next cycle push is accepted.
- 10 sustained pushes and pops, DEPTH=4 -> pointers wrap, output addresses are in order, no entry is lost or duplicated.
- Occupancy 3, flush_i=1 with request_i=1 and grant_i=1 -> grant_o=0, request_o=0, occupancy_o=0 next cycle.
- rst_ni asserted mid-stream with occupancy 2 -> request_o=0 and occupancy_o=0 immediately (asynchronously); clean operation after release.
